// File: rtl/load_unit_if.sv
// Memory port of the load unit: word-aligned read request plus read response.
// The unit drives the master modport and the data memory drives the slave modport.
interface load_unit_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_address;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_address,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_address,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/load_unit.sv
// Multi-cycle RISC-V load unit: effective address, word request, lane extract, extend.
// Define LOAD_MISALIGN_TRAP_EN to fault misaligned H/W/D loads instead of truncating the offset.
module load_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] immediate,
  load_unit_if.master     mem,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_value,
  output logic            load_fault
);
  localparam int LANE_BITS = $clog2(XLEN / 8);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state;
  logic [2:0]           funct3_q;
  logic [LANE_BITS-1:0] offset_q;
  logic [XLEN-1:0]      req_addr_q;

  logic [XLEN-1:0]      ea;
  logic [LANE_BITS-1:0] lane;
  logic [LANE_BITS-1:0] lane_mask;
  logic                 illegal;
  logic                 misaligned;
  logic                 fault;
  logic [XLEN-1:0]      shifted;
  logic [XLEN-1:0]      load_data;

  // Decode of the incoming load; only consumed while IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_mask  = '0;
    misaligned = 1'b0;
    ea         = rs1_value + immediate;
    lane       = ea[LANE_BITS-1:0];
    case (funct3[1:0])
      2'd1:    lane_mask = LANE_BITS'(1);
      2'd2:    lane_mask = LANE_BITS'(3);
      2'd3:    lane_mask = '1;
      default: lane_mask = '0;
    endcase
    illegal = (funct3 == 3'd7) ||
              ((XLEN == 32) && ((funct3 == 3'd3) || (funct3 == 3'd6)));
`ifdef LOAD_MISALIGN_TRAP_EN
    misaligned = |(lane & lane_mask);
`else
    misaligned = 1'b0;
`endif
    fault = illegal | misaligned;
  end

  // Lane extraction; funct3_q[2] selects zero extension (BU/HU/WU).
  always_comb begin
    shifted   = mem.mem_rsp_data >> {offset_q, 3'b000};
    load_data = shifted;
    case (funct3_q[1:0])
      2'd0: load_data = funct3_q[2] ? XLEN'(shifted[7:0])
                                    : XLEN'($signed(shifted[7:0]));
      2'd1: load_data = funct3_q[2] ? XLEN'(shifted[15:0])
                                    : XLEN'($signed(shifted[15:0]));
      2'd2: load_data = funct3_q[2] ? XLEN'(shifted[31:0])
                                    : XLEN'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      funct3_q   <= '0;
      offset_q   <= '0;
      req_addr_q <= '0;
      rd_value   <= '0;
      load_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load_valid) begin
          funct3_q <= funct3;
          // Offset is stored already aligned; with trapping enabled it is unchanged.
          offset_q <= lane & ~lane_mask;
          if (fault) begin
            rd_value   <= '0;
            load_fault <= 1'b1;
            state      <= DONE;
          end else begin
            load_fault <= 1'b0;
            req_addr_q <= {ea[XLEN-1:LANE_BITS], {LANE_BITS{1'b0}}};
            state      <= REQ;
          end
        end
        REQ: if (mem.mem_req_ready) state <= WAIT;
        WAIT: if (mem.mem_rsp_valid) begin
          rd_value <= load_data;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready          = (state == IDLE);
  assign rd_valid            = (state == DONE);
  assign mem.mem_req_valid   = (state == REQ);
  assign mem.mem_req_address = req_addr_q;
endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: a 32-bit and a 64-bit instance share clock and reset,
// each with a small memory model and a monitor that pops expected results on rd_valid.
module tb_load_unit;
  typedef struct {
    logic [63:0] value;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  exp_t q32[$];
  exp_t q64[$];

  // 32-bit instance
  logic        lv32 = 1'b0, lr32, rdv32, lf32;
  logic [2:0]  f3_32 = '0;
  logic [31:0] rs1_32 = '0, imm32 = '0, rdval32;
  load_unit_if #(.XLEN(32)) bus32 ();
  load_unit #(.XLEN(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv32), .load_ready(lr32),
    .funct3(f3_32), .rs1_value(rs1_32), .immediate(imm32), .mem(bus32),
    .rd_valid(rdv32), .rd_value(rdval32), .load_fault(lf32));

  // 64-bit instance
  logic        lv64 = 1'b0, lr64, rdv64, lf64;
  logic [2:0]  f3_64 = '0;
  logic [63:0] rs1_64 = '0, imm64 = '0, rdval64;
  load_unit_if #(.XLEN(64)) bus64 ();
  load_unit #(.XLEN(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv64), .load_ready(lr64),
    .funct3(f3_64), .rs1_value(rs1_64), .immediate(imm64), .mem(bus64),
    .rd_valid(rdv64), .rd_value(rdval64), .load_fault(lf64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model state; requests are stalled for 'stall' cycles, garbage responses are
  // shown during stalls, and the real response follows the handshake by one cycle.
  logic [31:0] word32 = '0, addr_first32 = '0, last_addr32 = '0;
  int stall32 = 0, stall_cnt32 = 0, hs32 = 0, req_cyc32 = 0, done32 = 0;
  bit rsp_next32 = 0, rsp_en32 = 1;
  logic [63:0] word64 = '0, addr_first64 = '0, last_addr64 = '0;
  int stall64 = 0, stall_cnt64 = 0, hs64 = 0, req_cyc64 = 0, done64 = 0;
  bit rsp_next64 = 0, rsp_en64 = 1;

  initial begin
    bus32.mem_req_ready = 1'b0; bus32.mem_rsp_valid = 1'b0; bus32.mem_rsp_data = '0;
    bus64.mem_req_ready = 1'b0; bus64.mem_rsp_valid = 1'b0; bus64.mem_rsp_data = '0;
  end

  always @(negedge clock) begin
    if (rsp_next32 && rsp_en32) begin
      bus32.mem_rsp_valid = 1'b1; bus32.mem_rsp_data = word32; rsp_next32 = 0;
    end else begin
      bus32.mem_rsp_valid = 1'b0; bus32.mem_rsp_data = ~word32;
    end
    if (bus32.mem_req_valid) begin
      req_cyc32++;
      if (stall_cnt32 == 0) addr_first32 = bus32.mem_req_address;
      else check("req_addr_stable32", 64'(bus32.mem_req_address), 64'(addr_first32));
      if (stall_cnt32 >= stall32) begin
        bus32.mem_req_ready = 1'b1; hs32++; last_addr32 = bus32.mem_req_address;
        rsp_next32 = 1; stall_cnt32 = 0;
      end else begin
        bus32.mem_req_ready = 1'b0; stall_cnt32++;
        bus32.mem_rsp_valid = 1'b1; bus32.mem_rsp_data = 32'hDEAD_BEEF;
      end
    end else begin
      bus32.mem_req_ready = 1'b0; stall_cnt32 = 0;
    end
  end

  always @(negedge clock) begin
    if (rsp_next64 && rsp_en64) begin
      bus64.mem_rsp_valid = 1'b1; bus64.mem_rsp_data = word64; rsp_next64 = 0;
    end else begin
      bus64.mem_rsp_valid = 1'b0; bus64.mem_rsp_data = ~word64;
    end
    if (bus64.mem_req_valid) begin
      req_cyc64++;
      if (stall_cnt64 == 0) addr_first64 = bus64.mem_req_address;
      else check("req_addr_stable64", bus64.mem_req_address, addr_first64);
      if (stall_cnt64 >= stall64) begin
        bus64.mem_req_ready = 1'b1; hs64++; last_addr64 = bus64.mem_req_address;
        rsp_next64 = 1; stall_cnt64 = 0;
      end else begin
        bus64.mem_req_ready = 1'b0; stall_cnt64++;
        bus64.mem_rsp_valid = 1'b1; bus64.mem_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end else begin
      bus64.mem_req_ready = 1'b0; stall_cnt64 = 0;
    end
  end

  // Monitors: every rd_valid cycle must match the oldest expected completion.
  always @(negedge clock) begin : mon32
    exp_t e;
    if (reset_n && rdv32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rd_valid32: got rd_valid=1, expected no pending load");
      end else begin
        e = q32.pop_front();
        check("rd_value32", 64'(rdval32), e.value);
        check("load_fault32", 64'(lf32), 64'(e.fault));
        check("latency32", 64'(cyc - e.acc), 64'(e.lat));
      end
      done32++;
    end
  end

  always @(negedge clock) begin : mon64
    exp_t e;
    if (reset_n && rdv64) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rd_valid64: got rd_valid=1, expected no pending load");
      end else begin
        e = q64.pop_front();
        check("rd_value64", rdval64, e.value);
        check("load_fault64", 64'(lf64), 64'(e.fault));
        check("latency64", 64'(cyc - e.acc), 64'(e.lat));
      end
      done64++;
    end
  end

  // Issue one load, push its expected completion, then wait (bounded) and check the bus side.
  task automatic issue(input bit wide, input logic [2:0] f3, input logic [63:0] rs1,
                       input logic [63:0] imm, input logic [63:0] word, input int stall,
                       input logic [63:0] exp_addr, input logic [63:0] exp_val,
                       input logic exp_fault, input int exp_lat);
    int hs0, rq0, d0, dn;
    exp_t e;
    @(negedge clock);
    e.value = exp_val; e.fault = exp_fault; e.lat = exp_lat; e.acc = cyc;
    if (wide) begin
      word64 = word; stall64 = stall; hs0 = hs64; rq0 = req_cyc64; d0 = done64;
      f3_64 = f3; rs1_64 = rs1; imm64 = imm; lv64 = 1'b1;
      check("load_ready64", 64'(lr64), 64'(1));
      q64.push_back(e);
    end else begin
      word32 = word[31:0]; stall32 = stall; hs0 = hs32; rq0 = req_cyc32; d0 = done32;
      f3_32 = f3; rs1_32 = rs1[31:0]; imm32 = imm[31:0]; lv32 = 1'b1;
      check("load_ready32", 64'(lr32), 64'(1));
      q32.push_back(e);
    end
    @(posedge clock);
    #1;
    lv32 = 1'b0; lv64 = 1'b0;
    dn = d0;
    for (int i = 0; i < 60; i++) begin
      dn = wide ? done64 : done32;
      if (dn != d0) break;
      @(negedge clock);
    end
    check("completed", 64'(dn - d0), 64'(1));
    if (wide) begin
      check("handshakes64", 64'(hs64 - hs0), exp_fault ? 64'(0) : 64'(1));
      if (exp_fault) check("req_cycles64", 64'(req_cyc64 - rq0), 64'(0));
      else check("req_address64", last_addr64, exp_addr);
    end else begin
      check("handshakes32", 64'(hs32 - hs0), exp_fault ? 64'(0) : 64'(1));
      if (exp_fault) check("req_cycles32", 64'(req_cyc32 - rq0), 64'(0));
      else check("req_address32", 64'(last_addr32), exp_addr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_load_ready", 64'(lr32), 64'(1));
    check("rst_req_valid", 64'(bus32.mem_req_valid), 64'(0));
    check("rst_req_address", 64'(bus32.mem_req_address), 64'(0));
    check("rst_rd_valid", 64'(rdv32), 64'(0));
    check("rst_rd_value", 64'(rdval32), 64'(0));
    check("rst_load_fault", 64'(lf32), 64'(0));
    check("rst_load_ready64", 64'(lr64), 64'(1));
    @(negedge clock);
    reset_n = 1'b1;

    // XLEN=32: f3, rs1, imm, word, stall, addr, value, fault, latency
    issue(0, 3'd0, 64'h100, 64'h3, 64'h80FF_1234, 0, 64'h100, 64'hFFFF_FF80, 0, 3);
    issue(0, 3'd5, 64'h200, 64'h2, 64'hBEEF_0000, 0, 64'h200, 64'h0000_BEEF, 0, 3);
    issue(0, 3'd1, 64'h200, 64'h2, 64'hBEEF_0000, 0, 64'h200, 64'hFFFF_BEEF, 0, 3);
    issue(0, 3'd2, 64'h300, 64'h0, 64'h1234_5678, 4, 64'h300, 64'h1234_5678, 0, 7);
    issue(0, 3'd7, 64'h40,  64'h0, 64'h1111_1111, 0, 64'h0,   64'h0,         1, 1);
    issue(0, 3'd3, 64'h40,  64'h0, 64'h1111_1111, 0, 64'h0,   64'h0,         1, 1);
    issue(0, 3'd6, 64'h40,  64'h0, 64'h1111_1111, 0, 64'h0,   64'h0,         1, 1);
    issue(0, 3'd4, 64'hFFFF_FFFF, 64'h2, 64'h0000_A500, 0, 64'h0, 64'hA5, 0, 3);
    issue(0, 3'd0, 64'h104, 64'hFFFF_FFFE, 64'h007F_0000, 0, 64'h100, 64'h7F, 0, 3);
`ifdef LOAD_MISALIGN_TRAP_EN
    issue(0, 3'd2, 64'h100, 64'h2, 64'hCAFE_F00D, 0, 64'h0, 64'h0, 1, 1);
    issue(0, 3'd1, 64'h200, 64'h3, 64'h8001_0000, 0, 64'h0, 64'h0, 1, 1);
`else
    issue(0, 3'd2, 64'h100, 64'h2, 64'hCAFE_F00D, 0, 64'h100, 64'hCAFE_F00D, 0, 3);
    issue(0, 3'd1, 64'h200, 64'h3, 64'h8001_0000, 0, 64'h200, 64'hFFFF_8001, 0, 3);
`endif

    // XLEN=64
    issue(1, 3'd6, 64'h1000, 64'h4, 64'hFFFF_FFFF_0000_0000, 0, 64'h1000, 64'h0000_0000_FFFF_FFFF, 0, 3);
    issue(1, 3'd2, 64'h1000, 64'h4, 64'hFFFF_FFFF_0000_0000, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3);
    issue(1, 3'd3, 64'h2000, 64'h8, 64'h0123_4567_89AB_CDEF, 0, 64'h2008, 64'h0123_4567_89AB_CDEF, 0, 3);
    issue(1, 3'd0, 64'h2000, 64'hF, 64'h8000_0000_0000_0000, 0, 64'h2008, 64'hFFFF_FFFF_FFFF_FF80, 0, 3);
    issue(1, 3'd7, 64'h2000, 64'h0, 64'h0, 0, 64'h0, 64'h0, 1, 1);
`ifdef LOAD_MISALIGN_TRAP_EN
    issue(1, 3'd3, 64'h3004, 64'h0, 64'h1111_2222_3333_4444, 0, 64'h0, 64'h0, 1, 1);
`else
    issue(1, 3'd3, 64'h3004, 64'h0, 64'h1111_2222_3333_4444, 0, 64'h3000, 64'h1111_2222_3333_4444, 0, 3);
`endif

    // Reset while waiting for a response; the late response must be dropped.
    @(negedge clock);
    rsp_en32 = 0; word32 = 32'h5555_AAAA; stall32 = 0;
    f3_32 = 3'd2; rs1_32 = 32'h400; imm32 = 32'h0; lv32 = 1'b1;
    @(posedge clock);
    #1 lv32 = 1'b0;
    repeat (3) @(negedge clock);
    check("wait_req_valid", 64'(bus32.mem_req_valid), 64'(0));
    check("wait_load_ready", 64'(lr32), 64'(0));
    #2 reset_n = 1'b0;
    #2;
    check("mid_rst_load_ready", 64'(lr32), 64'(1));
    check("mid_rst_req_valid", 64'(bus32.mem_req_valid), 64'(0));
    check("mid_rst_req_address", 64'(bus32.mem_req_address), 64'(0));
    check("mid_rst_rd_valid", 64'(rdv32), 64'(0));
    check("mid_rst_rd_value", 64'(rdval32), 64'(0));
    check("mid_rst_load_fault", 64'(lf32), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    rsp_en32 = 1;
    repeat (4) @(negedge clock);
    check("post_rst_rd_value", 64'(rdval32), 64'(0));
    check("post_rst_load_ready", 64'(lr32), 64'(1));
    check("post_rst_req_valid", 64'(bus32.mem_req_valid), 64'(0));

    // A normal load still completes after the dropped response.
    issue(0, 3'd2, 64'h500, 64'h4, 64'h0BAD_F00D, 0, 64'h504, 64'h0BAD_F00D, 0, 3);

    repeat (2) @(negedge clock);
    check("scoreboard32_drained", 64'(q32.size()), 64'(0));
    check("scoreboard64_drained", 64'(q64.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
